// File: rtl/wb_arbiter_2_8.sv
// wb_arbiter_2_8 -- two-master Wishbone arbiter onto one slave bus.
//
// Hands out whole bus cycles (a master keeps the slave for as long as it
// holds cyc), routes ack/err back to the current owner only, and aborts a
// stalled slave access with a watchdog so no master can hang forever.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   wbm0_* / wbm1_*   master-side Wishbone ports (master 0 / master 1)
//   wbs_*             slave-side Wishbone port
//   grant             one-hot owner {m1,m0}; 00 when idle or aborting
//   timeout_event     one-cycle pulse when the watchdog aborts an access
//   busy              high whenever the arbiter is not idle
//
// state  | meaning
// IDLE   | no owner, waiting for a cyc request
// GRANT0 | master 0 owns the slave bus
// GRANT1 | master 1 owns the slave bus
// ABORT  | watchdog fired; waiting for the aborted owner to drop cyc

module wb_arbiter_2_8 #(
  parameter int    ADDR_WIDTH = 36,
  parameter int    DATA_WIDTH = 8,
  parameter string ARB_TYPE   = "PRIORITY",
  parameter int    TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] wbm0_adr_i,
  input  logic [DATA_WIDTH-1:0] wbm0_dat_i,
  output logic [DATA_WIDTH-1:0] wbm0_dat_o,
  input  logic                  wbm0_we_i,
  input  logic                  wbm0_stb_i,
  output logic                  wbm0_ack_o,
  output logic                  wbm0_err_o,
  input  logic                  wbm0_cyc_i,
  input  logic [ADDR_WIDTH-1:0] wbm1_adr_i,
  input  logic [DATA_WIDTH-1:0] wbm1_dat_i,
  output logic [DATA_WIDTH-1:0] wbm1_dat_o,
  input  logic                  wbm1_we_i,
  input  logic                  wbm1_stb_i,
  output logic                  wbm1_ack_o,
  output logic                  wbm1_err_o,
  input  logic                  wbm1_cyc_i,
  output logic [ADDR_WIDTH-1:0] wbs_adr_o,
  input  logic [DATA_WIDTH-1:0] wbs_dat_i,
  output logic [DATA_WIDTH-1:0] wbs_dat_o,
  output logic                  wbs_we_o,
  output logic                  wbs_stb_o,
  input  logic                  wbs_ack_i,
  input  logic                  wbs_err_i,
  output logic                  wbs_cyc_o,
  output logic [1:0]            grant,
  output logic                  timeout_event,
  output logic                  busy
);

  localparam bit RR = (ARB_TYPE == "ROUND_ROBIN");
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = (TIMEOUT > 0) ? CW'(TIMEOUT) : '0;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, ABORT} state_t;

  state_t        state;
  logic          last;         // 1: master 1 was granted most recently
  logic          abort_owner;  // master whose access was aborted
  logic [CW-1:0] count;

  logic   own0, own1;
  logic   win_valid, win;
  state_t arb_state;
  logic [1:0] arb_grant;
  logic   stall, expire;

  assign own0 = (state == GRANT0);
  assign own1 = (state == GRANT1);

  // Winner among current requesters. On release the owner's cyc is already
  // low, so only the other master can win the handoff.
  always_comb begin
    win_valid = wbm0_cyc_i | wbm1_cyc_i;
    win       = 1'b0;
    if (wbm0_cyc_i && wbm1_cyc_i) win = RR ? ~last : 1'b0;
    else if (wbm1_cyc_i)          win = 1'b1;
    arb_state = IDLE;
    arb_grant = 2'b00;
    if (win_valid) begin
      arb_state = win ? GRANT1 : GRANT0;
      arb_grant = win ? 2'b10 : 2'b01;
    end
  end

  // Slave bus mux; address/data default to master 0 when nobody owns it.
  assign wbs_adr_o = own1 ? wbm1_adr_i : wbm0_adr_i;
  assign wbs_dat_o = own1 ? wbm1_dat_i : wbm0_dat_i;
  assign wbs_we_o  = (own0 & wbm0_we_i)  | (own1 & wbm1_we_i);
  assign wbs_stb_o = (own0 & wbm0_stb_i) | (own1 & wbm1_stb_i);
  assign wbs_cyc_o = (own0 & wbm0_cyc_i) | (own1 & wbm1_cyc_i);

  assign wbm0_dat_o = wbs_dat_i;
  assign wbm1_dat_o = wbs_dat_i;

  // timeout_event is high only during the first ABORT cycle, so it doubles
  // as the one-shot error strobe back to the aborted master.
  assign wbm0_ack_o = own0 & wbs_ack_i;
  assign wbm1_ack_o = own1 & wbs_ack_i;
  assign wbm0_err_o = (own0 & wbs_err_i) | (timeout_event & ~abort_owner);
  assign wbm1_err_o = (own1 & wbs_err_i) | (timeout_event &  abort_owner);

  assign busy = (state != IDLE);

  assign stall  = wbs_stb_o & ~wbs_ack_i & ~wbs_err_i;
  assign expire = (TIMEOUT > 0) && stall && (count == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant         <= 2'b00;
      last          <= 1'b1;
      abort_owner   <= 1'b0;
      count         <= '0;
      timeout_event <= 1'b0;
    end else begin
      timeout_event <= 1'b0;
      if ((TIMEOUT > 0) && stall) begin
        if (count != CNT_MAX) count <= count + 1'b1;
      end else begin
        count <= '0;
      end

      case (state)
        IDLE: begin
          state <= arb_state;
          grant <= arb_grant;
          if (win_valid) last <= win;
        end
        GRANT0, GRANT1: begin
          if (!(own1 ? wbm1_cyc_i : wbm0_cyc_i)) begin
            state <= arb_state;
            grant <= arb_grant;
            if (win_valid) last <= win;
          end else if (expire) begin
            state         <= ABORT;
            grant         <= 2'b00;
            timeout_event <= 1'b1;
            abort_owner   <= own1;
            count         <= '0;
          end
        end
        ABORT: begin
          if (!(abort_owner ? wbm1_cyc_i : wbm0_cyc_i)) begin
            state <= arb_state;
            grant <= arb_grant;
            if (win_valid) last <= win;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2_8.sv
module tb_wb_arbiter_2_8;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       mc_cyc, mc_stb, mc_we;
  logic [1:0][35:0] mc_adr;
  logic [1:0][7:0]  mc_dat;
  logic [7:0]       s_dat;
  logic             s_ack, s_err;

  logic [1:0][7:0]  o_m0dat, o_m1dat, o_sdat;
  logic [1:0]       o_m0ack, o_m1ack, o_m0err, o_m1err;
  logic [1:0][35:0] o_adr;
  logic [1:0]       o_we, o_stb, o_cyc, o_toe, o_busy;
  logic [1:0][1:0]  o_grant;

  wb_arbiter_2_8 #(.ADDR_WIDTH(36), .DATA_WIDTH(8), .ARB_TYPE("PRIORITY"), .TIMEOUT(TO)) u_pri (
    .clk(clk), .rst_n(rst_n),
    .wbm0_adr_i(mc_adr[0]), .wbm0_dat_i(mc_dat[0]), .wbm0_dat_o(o_m0dat[0]), .wbm0_we_i(mc_we[0]),
    .wbm0_stb_i(mc_stb[0]), .wbm0_ack_o(o_m0ack[0]), .wbm0_err_o(o_m0err[0]), .wbm0_cyc_i(mc_cyc[0]),
    .wbm1_adr_i(mc_adr[1]), .wbm1_dat_i(mc_dat[1]), .wbm1_dat_o(o_m1dat[0]), .wbm1_we_i(mc_we[1]),
    .wbm1_stb_i(mc_stb[1]), .wbm1_ack_o(o_m1ack[0]), .wbm1_err_o(o_m1err[0]), .wbm1_cyc_i(mc_cyc[1]),
    .wbs_adr_o(o_adr[0]), .wbs_dat_i(s_dat), .wbs_dat_o(o_sdat[0]), .wbs_we_o(o_we[0]),
    .wbs_stb_o(o_stb[0]), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_cyc_o(o_cyc[0]),
    .grant(o_grant[0]), .timeout_event(o_toe[0]), .busy(o_busy[0]));

  wb_arbiter_2_8 #(.ADDR_WIDTH(36), .DATA_WIDTH(8), .ARB_TYPE("ROUND_ROBIN"), .TIMEOUT(TO)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .wbm0_adr_i(mc_adr[0]), .wbm0_dat_i(mc_dat[0]), .wbm0_dat_o(o_m0dat[1]), .wbm0_we_i(mc_we[0]),
    .wbm0_stb_i(mc_stb[0]), .wbm0_ack_o(o_m0ack[1]), .wbm0_err_o(o_m0err[1]), .wbm0_cyc_i(mc_cyc[0]),
    .wbm1_adr_i(mc_adr[1]), .wbm1_dat_i(mc_dat[1]), .wbm1_dat_o(o_m1dat[1]), .wbm1_we_i(mc_we[1]),
    .wbm1_stb_i(mc_stb[1]), .wbm1_ack_o(o_m1ack[1]), .wbm1_err_o(o_m1err[1]), .wbm1_cyc_i(mc_cyc[1]),
    .wbs_adr_o(o_adr[1]), .wbs_dat_i(s_dat), .wbs_dat_o(o_sdat[1]), .wbs_we_o(o_we[1]),
    .wbs_stb_o(o_stb[1]), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_cyc_o(o_cyc[1]),
    .grant(o_grant[1]), .timeout_event(o_toe[1]), .busy(o_busy[1]));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model, one per DUT (0: priority, 1: round robin).
  // owner = -1 means nobody holds the bus.
  int ref_owner[2], ref_last[2], ref_who[2], ref_wait[2];
  bit ref_abort[2], ref_first[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ref_owner[d] = -1; ref_last[d] = 1; ref_who[d] = 0; ref_wait[d] = 0;
      ref_abort[d] = 0;  ref_first[d] = 0;
    end
  endtask

  function automatic int pick(input int d);
    if (mc_cyc[0] && mc_cyc[1]) return (d == 1) ? 1 - ref_last[d] : 0;
    if (mc_cyc[0]) return 0;
    if (mc_cyc[1]) return 1;
    return -1;
  endfunction

  task automatic take_bus(input int d);
    int w;
    w = pick(d);
    ref_owner[d] = w;
    if (w >= 0) ref_last[d] = w;
  endtask

  task automatic model_step(input int d);
    int  o;
    bit  stalled;
    o = ref_owner[d];
    stalled = (o >= 0) && mc_stb[o] && !s_ack && !s_err;
    if (ref_abort[d]) begin
      ref_first[d] = 0;
      ref_wait[d]  = 0;
      if (!mc_cyc[ref_who[d]]) begin
        ref_abort[d] = 0;
        take_bus(d);
      end
    end else if (o < 0) begin
      ref_wait[d] = 0;
      take_bus(d);
    end else if (!mc_cyc[o]) begin
      ref_wait[d] = stalled ? ref_wait[d] + 1 : 0;
      take_bus(d);
    end else if (stalled && ref_wait[d] == TO - 1) begin
      ref_abort[d] = 1; ref_first[d] = 1; ref_who[d] = o;
      ref_owner[d] = -1; ref_wait[d] = 0;
    end else begin
      ref_wait[d] = stalled ? ref_wait[d] + 1 : 0;
    end
  endtask

  task automatic check_dut(input int d);
    int  o;
    bit  g;
    int  oi;
    bit  ev;
    o  = ref_owner[d];
    g  = (o >= 0);
    oi = g ? o : 0;
    ev = ref_abort[d] && ref_first[d];
    check($sformatf("d%0d_grant", d), o_grant[d], g ? (oi == 1 ? 2'b10 : 2'b01) : 2'b00);
    check($sformatf("d%0d_busy", d), o_busy[d], g || ref_abort[d]);
    check($sformatf("d%0d_toe", d), o_toe[d], ev);
    check($sformatf("d%0d_scyc", d), o_cyc[d], g && mc_cyc[oi]);
    check($sformatf("d%0d_sstb", d), o_stb[d], g && mc_stb[oi]);
    check($sformatf("d%0d_swe", d), o_we[d], g && mc_we[oi]);
    check($sformatf("d%0d_sadr", d), o_adr[d], (g && oi == 1) ? mc_adr[1] : mc_adr[0]);
    check($sformatf("d%0d_sdat", d), o_sdat[d], (g && oi == 1) ? mc_dat[1] : mc_dat[0]);
    check($sformatf("d%0d_m0ack", d), o_m0ack[d], g && oi == 0 && s_ack);
    check($sformatf("d%0d_m1ack", d), o_m1ack[d], g && oi == 1 && s_ack);
    check($sformatf("d%0d_m0err", d), o_m0err[d], (g && oi == 0 && s_err) || (ev && ref_who[d] == 0));
    check($sformatf("d%0d_m1err", d), o_m1err[d], (g && oi == 1 && s_err) || (ev && ref_who[d] == 1));
    check($sformatf("d%0d_m0dat", d), o_m0dat[d], s_dat);
    check($sformatf("d%0d_m1dat", d), o_m1dat[d], s_dat);
  endtask

  // Staged values for directed cycles and random-stimulus state.
  logic [1:0] d_cyc, d_stb, d_we;
  logic       d_ack, d_err, want_rst;
  int left[2], hold[2];
  int hang = 0;

  task automatic drive_random();
    int r;
    for (int m = 0; m < 2; m++) begin
      if (left[m] == 0 && $urandom_range(3) == 0) begin
        left[m] = $urandom_range(40, 1);
        hold[m] = $urandom_range(1);
      end
      if (left[m] > 0) begin
        mc_cyc[m] = 1'b1;
        mc_stb[m] = (hold[m] != 0) ? 1'b1 : 1'($urandom_range(1));
        left[m]--;
      end else begin
        mc_cyc[m] = 1'b0;
        mc_stb[m] = 1'b0;
      end
      mc_we[m] = 1'($urandom_range(1));
    end
    if (hang > 0) begin
      hang--;
      s_ack = 1'b0; s_err = 1'b0;
    end else begin
      if ($urandom_range(15) == 0) hang = $urandom_range(30, 10);
      r = $urandom_range(7);
      s_ack = (r <= 2) || (r == 4);
      s_err = (r == 3) || (r == 4);
    end
  endtask

  task automatic run_cycle(input bit rnd);
    @(negedge clk);
    rst_n = want_rst;
    for (int m = 0; m < 2; m++) begin
      mc_adr[m] = 36'({$urandom(), $urandom()});
      mc_dat[m] = 8'($urandom());
    end
    s_dat = 8'($urandom());
    if (rnd) drive_random();
    else begin
      mc_cyc = d_cyc; mc_stb = d_stb; mc_we = d_we; s_ack = d_ack; s_err = d_err;
    end
    #1;
    for (int d = 0; d < 2; d++) check_dut(d);
    if (rst_n) for (int d = 0; d < 2; d++) model_step(d);
  endtask

  task automatic stage(input logic [1:0] cyc, input logic [1:0] stb, input logic [1:0] we,
                       input logic ack, input logic err, input int n);
    d_cyc = cyc; d_stb = stb; d_we = we; d_ack = ack; d_err = err;
    for (int i = 0; i < n; i++) run_cycle(1'b0);
  endtask

  initial begin
    rst_n = 1'b0; want_rst = 1'b0;
    mc_cyc = '0; mc_stb = '0; mc_we = '0; mc_adr = '0; mc_dat = '0;
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0;
    left[0] = 0; left[1] = 0; hold[0] = 0; hold[1] = 0;
    model_reset();

    // Reset state, then release.
    stage(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2);
    want_rst = 1'b1;
    stage(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1);

    // m0 single write acked after two wait cycles, then release.
    stage(2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 3);
    stage(2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1);
    stage(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2);

    // Both requesting: m0 periodically drops cyc to exercise direct handoff.
    for (int i = 0; i < 16; i++)
      stage({1'b1, 1'(i % 4 != 3)}, 2'b00, 2'b00, 1'b0, 1'b0, 1);
    stage(2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1);
    stage(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2);

    // Hung slave on m0: watchdog abort, then a late ack that nobody sees.
    stage(2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 19);
    stage(2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 1);
    stage(2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 2);
    stage(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2);

    // Slave error during an m1 read.
    stage(2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 3);
    stage(2'b10, 2'b10, 2'b00, 1'b0, 1'b1, 1);
    stage(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2);

    // Async reset in the middle of an m1 transfer.
    stage(2'b10, 2'b10, 2'b10, 1'b0, 1'b0, 3);
    #1 rst_n = 1'b0; want_rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_rst_grant", d), o_grant[d], 2'b00);
      check($sformatf("d%0d_rst_cyc", d), o_cyc[d], 1'b0);
      check($sformatf("d%0d_rst_busy", d), o_busy[d], 1'b0);
    end
    model_reset();
    stage(2'b10, 2'b10, 2'b10, 1'b0, 1'b0, 1);
    want_rst = 1'b1;
    stage(2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 3);
    check("rr_first_grant_after_reset", o_grant[1], 2'b01);
    stage(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) run_cycle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
